// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file bus: read ports, issue reservation and writeback.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_used;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  logic                issue_valid;
  logic                issue_wen;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;

  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;

  logic                flush;

  // Decode / pipeline control side
  modport master (
    output rd_addr, rd_used, issue_valid, issue_wen, issue_rd,
           wb_en, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, issue_ready
  );

  // Register file side
  modport slave (
    input  rd_addr, rd_used, issue_valid, issue_wen, issue_rd,
           wb_en, wb_addr, wb_data, flush,
    output rd_data, rd_busy, issue_ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register pending-write counters,
// writeback-to-read bypass and hazard-based issue gating for the ID stage.
module regfile_scoreboard #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int MAX_PEND  = 3,
  parameter int BYPASS_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_scoreboard_if.slave   bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(MAX_PEND + 1);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [CW-1:0]   pend_q [NREGS];
  logic [CW-1:0]   pend_d [NREGS];

  logic [NRD-1:0]  rdBusy;
  logic            hazard;
  logic            satStall;
  logic            issueReady;
  logic            fire;
  logic            ret;

  // Per-port combinational read: x0 is zero, a same-cycle writeback wins
  // over the stored value and retires one reservation early.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          isZero;
    logic          hit;

    assign a      = bus.rd_addr[i*AW +: AW];
    assign isZero = (a == '0);
    assign hit    = (BYPASS_EN != 0) && bus.wb_en && (bus.wb_addr == a);

    assign bus.rd_data[i*XLEN +: XLEN] = isZero ? '0 :
                                         hit    ? bus.wb_data : regs_q[a];
    assign rdBusy[i] = isZero ? 1'b0 :
                       hit    ? (pend_q[a] > CW'(1)) : (pend_q[a] != '0);
  end

  assign bus.rd_busy = rdBusy;

  // A consumed operand that is still in flight blocks issue, as does a
  // destination whose counter is already full (registered count only).
  assign hazard     = |(bus.rd_used & rdBusy);
  assign satStall   = bus.issue_wen && (bus.issue_rd != '0) &&
                      (pend_q[bus.issue_rd] == CW'(MAX_PEND));
  assign issueReady = !hazard && !satStall;
  assign bus.issue_ready = issueReady;

  assign fire = bus.issue_valid && issueReady && bus.issue_wen && (bus.issue_rd != '0);
  assign ret  = bus.wb_en && (bus.wb_addr != '0);

  // Next pending count: issue and retire to the same register cancel,
  // retiring an idle register never underflows, flush drops everything.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      if (r != 0) begin
        logic inc;
        logic dec;
        inc = fire && (bus.issue_rd == AW'(r));
        dec = ret && (bus.wb_addr == AW'(r)) && (pend_q[r] != '0);
        if (inc && !dec) begin
          pend_d[r] = pend_q[r] + CW'(1);
        end else if (dec && !inc) begin
          pend_d[r] = pend_q[r] - CW'(1);
        end
      end else begin
        pend_d[r] = '0;
      end
      if (bus.flush) begin
        pend_d[r] = '0;
      end
    end
  end

  // Register and counter state; writeback data lands even during a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= pend_d[r];
        if (r == 0) begin
          regs_q[r] <= '0;
        end else if (ret && (bus.wb_addr == AW'(r))) begin
          regs_q[r] <= bus.wb_data;
        end
      end
    end
  end
endmodule
